// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter between the LSU pipeline and the MDU, with a per-register
// pending scoreboard that gates issue and reports source-operand hazards.
module rf_wb_arbiter #(
    parameter int unsigned RegWidth = 64,
    parameter int unsigned NREG     = 32,
    localparam int unsigned AddrWidth = 5
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 iss_valid,
    input  logic [AddrWidth-1:0] iss_rd,
    output logic                 iss_ready,

    input  logic                 p_valid,
    output logic                 p_ready,
    input  logic [AddrWidth-1:0] p_rd,
    input  logic [RegWidth-1:0]  p_data,

    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [AddrWidth-1:0] m_rd,
    input  logic [RegWidth-1:0]  m_data,

    input  logic [AddrWidth-1:0] rs1,
    input  logic [AddrWidth-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,

    output logic                 rf_wen,
    output logic [AddrWidth-1:0] rf_waddr,
    output logic [RegWidth-1:0]  rf_wdata
);

    typedef struct packed {
        logic [AddrWidth-1:0] rd;
        logic [RegWidth-1:0]  data;
    } wr_req_t;

    // One-hot register select; x0 and indices beyond NREG never select a bit.
    function automatic logic [NREG-1:0] reg_sel(input logic [AddrWidth-1:0] rd);
        logic [NREG-1:0] sel;
        sel    = NREG'(1) << rd;
        sel[0] = 1'b0;
        return sel;
    endfunction

    logic [NREG-1:0]      pend_q;
    logic [NREG-1:0]      pend_d;
    logic                 prefer_m_q;
    logic                 prefer_m_d;

    logic                 contended;
    logic                 grant_p;
    logic                 grant_m;
    logic                 win_valid;
    wr_req_t              win;
    logic                 iss_fire;

    logic                 rf_wen_d;
    logic [AddrWidth-1:0] rf_waddr_d;
    logic [RegWidth-1:0]  rf_wdata_d;

    // Arbitration, scoreboard next state and write-port next state.
    always_comb begin
        contended  = 1'b0;
        grant_p    = 1'b0;
        grant_m    = 1'b0;
        win_valid  = 1'b0;
        win        = '0;
        iss_fire   = 1'b0;
        iss_ready  = 1'b0;
        p_ready    = 1'b0;
        m_ready    = 1'b0;
        rs1_busy   = 1'b0;
        rs2_busy   = 1'b0;
        pend_d     = pend_q;
        prefer_m_d = prefer_m_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;

        contended = p_valid & m_valid;
        grant_p   = p_valid & (~m_valid | ~prefer_m_q);
        grant_m   = m_valid & ~grant_p;
        win_valid = grant_p | grant_m;
        win.rd    = grant_p ? p_rd   : m_rd;
        win.data  = grant_p ? p_data : m_data;

        p_ready   = grant_p;
        m_ready   = grant_m;

        // Loser of a contended cycle gets priority on the next contended cycle.
        if (contended) begin
            prefer_m_d = grant_p;
        end

        // A grant to the same rd releases the hazard for a same-cycle issue.
        iss_ready = (iss_rd == '0)
                  | ~(|(pend_q & reg_sel(iss_rd)))
                  | (win_valid & (win.rd == iss_rd));
        iss_fire  = iss_valid & iss_ready;

        // Clear on write-back first, then set on issue so a same-cycle issue wins.
        if (win_valid) begin
            pend_d = pend_d & ~reg_sel(win.rd);
        end
        if (iss_fire) begin
            pend_d = pend_d | reg_sel(iss_rd);
        end

        rs1_busy = |(pend_q & reg_sel(rs1));
        rs2_busy = |(pend_q & reg_sel(rs2));

        rf_wen_d = win_valid & (win.rd != '0);
        if (rf_wen_d) begin
            rf_waddr_d = win.rd;
            rf_wdata_d = win.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q     <= '0;
            prefer_m_q <= 1'b0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            pend_q     <= pend_d;
            prefer_m_q <= prefer_m_d;
            rf_wen     <= rf_wen_d;
            rf_waddr   <= rf_waddr_d;
            rf_wdata   <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: scenario tasks with inline checks plus a
// write-back scoreboard that pairs every rf_wen pulse with a queued expectation.
module tb_rf_wb_arbiter;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst;
    logic         iss_valid;
    logic [4:0]   iss_rd;
    logic         iss_ready;
    logic         p_valid;
    logic         p_ready;
    logic [4:0]   p_rd;
    logic [W-1:0] p_data;
    logic         m_valid;
    logic         m_ready;
    logic [4:0]   m_rd;
    logic [W-1:0] m_data;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic         rs1_busy;
    logic         rs2_busy;
    logic         rf_wen;
    logic [4:0]   rf_waddr;
    logic [W-1:0] rf_wdata;

    typedef struct {
        logic [4:0]   addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;

    rf_wb_arbiter #(.RegWidth(W), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // Scoreboard: every observed register write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && rf_wen === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got write addr=%0d data=%h, expected no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_waddr !== mon_e.addr || rf_wdata !== mon_e.data) begin
                    n_err++;
                    $display("FAIL wb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             rf_waddr, rf_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic idle();
        iss_valid = 1'b0;
        p_valid   = 1'b0;
        m_valid   = 1'b0;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
        p_valid = 1'b1; p_rd = 5'd3; p_data = 64'hDEAD;
        m_rd = 5'd0; m_data = '0;
        @(negedge clk); #1;
        n_cmp++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL rst_wen: got %b expected 0", rf_wen); end
        n_cmp++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL rst_waddr: got %0d expected 0", rf_waddr); end
        n_cmp++; if (rf_wdata !== 64'd0) begin n_err++; $display("FAIL rst_wdata: got %h expected 0", rf_wdata); end
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL rst_iss_ready: got %b expected 1", iss_ready); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL rst_rs1_busy: got %b expected 0", rs1_busy); end
        n_cmp++; if (p_ready !== 1'b1 || m_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got p=%b m=%b expected p=1 m=0", p_ready, m_ready); end
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        n_cmp++; if (rs1_busy !== 1'b0 || rf_wen !== 1'b0) begin n_err++; $display("FAIL rst_release: got busy=%b wen=%b expected 0 0", rs1_busy, rf_wen); end
    endtask

    task automatic test_issue_busy();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd5; rs1 = 5'd5;
        #1;
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL ib_iss_ready: got %b expected 1", iss_ready); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL ib_busy_same_cycle: got %b expected 0", rs1_busy); end
        @(negedge clk);
        idle();
        p_valid = 1'b1; p_rd = 5'd5; p_data = 64'h1234;
        push_wr(5'd5, 64'h1234);
        #1;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL ib_busy_set: got %b expected 1", rs1_busy); end
        n_cmp++; if (p_ready !== 1'b1) begin n_err++; $display("FAIL ib_p_ready: got %b expected 1", p_ready); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234) begin
            n_err++; $display("FAIL ib_write: got wen=%b addr=%0d data=%h expected 1 5 1234", rf_wen, rf_waddr, rf_wdata); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL ib_busy_clear: got %b expected 0", rs1_busy); end
        @(negedge clk); #1;
        n_cmp++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234) begin
            n_err++; $display("FAIL ib_hold: got wen=%b addr=%0d data=%h expected 0 5 1234", rf_wen, rf_waddr, rf_wdata); end
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            p_valid = 1'b1; p_rd = 5'd1; p_data = 64'hAAAA_0001;
            m_valid = 1'b1; m_rd = 5'd2; m_data = 64'hBBBB_0002;
            if (k % 2 == 0) push_wr(5'd1, 64'hAAAA_0001);
            else            push_wr(5'd2, 64'hBBBB_0002);
            #1;
            n_cmp++;
            if (p_ready !== (k % 2 == 0) || m_ready !== (k % 2 == 1)) begin
                n_err++; $display("FAIL rr_grant%0d: got p=%b m=%b expected p=%b m=%b",
                                  k, p_ready, m_ready, k % 2 == 0, k % 2 == 1);
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd2) begin n_err++; $display("FAIL rr_last: got wen=%b addr=%0d expected 1 2", rf_wen, rf_waddr); end
    endtask

    task automatic test_single_m();
        @(negedge clk);
        m_valid = 1'b1; m_rd = 5'd10; m_data = 64'hA0;
        push_wr(5'd10, 64'hA0);
        #1;
        n_cmp++; if (m_ready !== 1'b1 || p_ready !== 1'b0) begin n_err++; $display("FAIL sm_alone: got p=%b m=%b expected p=0 m=1", p_ready, m_ready); end
        @(negedge clk);
        p_valid = 1'b1; p_rd = 5'd11; p_data = 64'hB0;
        m_valid = 1'b1; m_rd = 5'd12; m_data = 64'hC0;
        push_wr(5'd11, 64'hB0);
        #1;
        n_cmp++; if (p_ready !== 1'b1 || m_ready !== 1'b0) begin n_err++; $display("FAIL sm_ptr_kept: got p=%b m=%b expected p=1 m=0", p_ready, m_ready); end
        @(negedge clk);
        p_valid = 1'b0;
        push_wr(5'd12, 64'hC0);
        #1;
        n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL sm_waiter: got m=%b expected 1", m_ready); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_issue_stall();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd7; rs2 = 5'd7;
        #1;
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL is_first: got %b expected 1", iss_ready); end
        @(negedge clk); #1;
        n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL is_stall: got %b expected 0", iss_ready); end
        n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL is_rs2_busy: got %b expected 1", rs2_busy); end
        @(negedge clk);
        p_valid = 1'b1; p_rd = 5'd7; p_data = 64'h77;
        push_wr(5'd7, 64'h77);
        #1;
        n_cmp++; if (iss_ready !== 1'b1 || p_ready !== 1'b1) begin n_err++; $display("FAIL is_release: got iss=%b p=%b expected 1 1", iss_ready, p_ready); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL is_set_wins: got %b expected 1", rs2_busy); end
        @(negedge clk);
        m_valid = 1'b1; m_rd = 5'd7; m_data = 64'h7777;
        push_wr(5'd7, 64'h7777);
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL is_cleared: got %b expected 0", rs2_busy); end
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd3; rs1 = 5'd3;
        @(negedge clk);
        idle();
        m_valid = 1'b1; m_rd = 5'd0; m_data = 64'hFFFF;
        #1;
        n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL rz_ready: got %b expected 1", m_ready); end
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL rz_pend_set: got %b expected 1", rs1_busy); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL rz_wen: got %b expected 0", rf_wen); end
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL rz_pend_kept: got %b expected 1", rs1_busy); end
        iss_rd = 5'd0; iss_valid = 1'b1;
        #1;
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL rz_iss_x0: got %b expected 1", iss_ready); end
        iss_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        p_valid = 1'b1; p_rd = 5'd9; p_data = 64'h99;
        rs1 = 5'd3;
        @(posedge clk); #1;
        n_cmp++; if (rf_wen !== 1'b1 || rs1_busy !== 1'b1) begin n_err++; $display("FAIL rm_pre: got wen=%b busy=%b expected 1 1", rf_wen, rs1_busy); end
        #1;
        rst = 1'b0;
        idle();
        #1;
        n_cmp++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
            n_err++; $display("FAIL rm_async: got wen=%b addr=%0d data=%h expected 0 0 0", rf_wen, rf_waddr, rf_wdata); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL rm_pend: got %b expected 0", rs1_busy); end
        @(negedge clk);
        rst = 1'b1;
        p_valid = 1'b1; p_rd = 5'd4; p_data = 64'h44;
        push_wr(5'd4, 64'h44);
        #1;
        n_cmp++; if (p_ready !== 1'b1) begin n_err++; $display("FAIL rm_first: got %b expected 1", p_ready); end
        @(negedge clk);
        p_valid = 1'b1; p_rd = 5'd13; p_data = 64'hD13;
        m_valid = 1'b1; m_rd = 5'd14; m_data = 64'hE14;
        push_wr(5'd13, 64'hD13);
        #1;
        n_cmp++; if (p_ready !== 1'b1 || m_ready !== 1'b0) begin n_err++; $display("FAIL rm_ptr: got p=%b m=%b expected 1 0", p_ready, m_ready); end
        @(negedge clk);
        p_valid = 1'b0;
        push_wr(5'd14, 64'hE14);
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        iss_rd = '0; p_rd = '0; p_data = '0; m_rd = '0; m_data = '0; rs1 = '0; rs2 = '0;
        test_reset();
        test_issue_busy();
        test_round_robin();
        test_single_m();
        test_issue_stall();
        test_rd_zero();
        test_reset_mid();
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL wb_drain: got %0d writes still outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
